// File: rtl/alu_pkg.sv
// Shared opcode / function-code definitions for the execute-stage ALU.
package alu_pkg;

    // OpCode that selects an R-type operation through FuncCode
    localparam logic [3:0] OP_RTYPE = 4'h0;

    // R-type function codes
    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_MUL = 4'd2;
    localparam logic [3:0] FN_DIV = 4'd3;
    localparam logic [3:0] FN_AND = 4'd4;
    localparam logic [3:0] FN_OR  = 4'd5;
    localparam logic [3:0] FN_SLL = 4'd8;
    localparam logic [3:0] FN_SRL = 4'd9;
    localparam logic [3:0] FN_ROL = 4'd10;
    localparam logic [3:0] FN_ROR = 4'd11;

    // Shifter mode: the low two FuncCode bits of the shift/rotate group
    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_ROL = 2'd2,
        SH_ROR = 2'd3
    } shift_e;

endpackage

// File: rtl/alu16_shifter.sv
// Combinational barrel shifter/rotator: SLL, SRL, ROL, ROR by 0-15.
module alu16_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [3:0]       amt,
    input  shift_e           mode,
    output logic [WIDTH-1:0] y
);

    logic             dir_right;
    logic             rotate;
    logic [WIDTH-1:0] v;
    logic [2*WIDTH-1:0] dbl;

    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            r[i] = x[WIDTH-1-i];
        end
        return r;
    endfunction

    assign dir_right = (mode == SH_SRL) || (mode == SH_ROR);
    assign rotate    = (mode == SH_ROL) || (mode == SH_ROR);

    // Right-direction ops run through the left-direction stages on a bit-reversed word
    always_comb begin
        dbl = '0;
        v   = dir_right ? bit_reverse(a) : a;
        for (int unsigned k = 0; k < 4; k++) begin
            if (amt[k]) begin
                dbl = {v, v} << (1 << k);
                v   = rotate ? dbl[2*WIDTH-1:WIDTH] : (v << (1 << k));
            end
        end
        y = dir_right ? bit_reverse(v) : v;
    end

endmodule

// File: rtl/alu16.sv
// 16-bit signed execute-stage ALU with registered results, flags and stall hold.
module alu16
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       OpCode,
    input  logic [3:0]       FuncCode,
    input  logic [3:0]       RegOp2,
    input  logic             stall,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUOut1,
    output logic [WIDTH-1:0] ALUOut2,
    output logic             Zero,
    output logic             Sign,
    output logic             Overflow,
    output logic             DivByZero
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [3:0]               fn;
    logic [WIDTH-1:0]         sum;
    logic [WIDTH-1:0]         diff;
    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]         divisor;
    logic signed [WIDTH-1:0]  quot;
    logic signed [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]         sh_y;

    logic [WIDTH-1:0] res1;
    logic [WIDTH-1:0] res2;
    logic             zf;
    logic             sf;
    logic             of;
    logic             dz;

    alu16_shifter #(.WIDTH(WIDTH)) u_shifter (
        .a    (A),
        .amt  (RegOp2),
        .mode (shift_e'(FuncCode[1:0])),
        .y    (sh_y)
    );

    assign fn      = (OpCode == OP_RTYPE) ? FuncCode : FN_ADD;
    assign sum     = A + B;
    assign diff    = A - B;
    assign prod    = $signed(A) * $signed(B);
    // Divisor forced to 1 on B == 0 so the divider never sees zero; result is discarded
    assign divisor = (B == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : B;
    assign quot    = $signed(A) / $signed(divisor);
    assign rem     = $signed(A) % $signed(divisor);

    // Operation select and flag generation
    always_comb begin
        res1 = '0;
        res2 = '0;
        of   = 1'b0;
        dz   = 1'b0;
        case (fn)
            FN_ADD: begin
                res1 = sum;
                of   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            FN_SUB: begin
                res1 = diff;
                of   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            FN_MUL: begin
                res1 = prod[WIDTH-1:0];
                res2 = prod[2*WIDTH-1:WIDTH];
            end
            FN_DIV: begin
                if (B == '0) begin
                    dz = 1'b1;
                end else if ((A == MIN_NEG) && (B == '1)) begin
                    res1 = MIN_NEG;
                    of   = 1'b1;
                end else begin
                    res1 = quot;
                    res2 = rem;
                end
            end
            FN_AND: res1 = A & B;
            FN_OR:  res1 = A | B;
            FN_SLL, FN_SRL, FN_ROL, FN_ROR: res1 = sh_y;
            default: ;
        endcase
        zf = (fn == FN_MUL) ? (prod == '0) : (res1 == '0);
        sf = (fn == FN_MUL) ? prod[2*WIDTH-1] : res1[WIDTH-1];
    end

    // Output registers: reset wins over stall, stall holds everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ALUOut1   <= '0;
            ALUOut2   <= '0;
            Zero      <= 1'b0;
            Sign      <= 1'b0;
            Overflow  <= 1'b0;
            DivByZero <= 1'b0;
        end else if (!stall) begin
            ALUOut1   <= res1;
            ALUOut2   <= res2;
            Zero      <= zf;
            Sign      <= sf;
            Overflow  <= of;
            DivByZero <= dz;
        end
    end

endmodule

// File: tb/tb_alu16.sv
// Self-checking bench for alu16: directed test-plan steps plus randomized traffic
// checked against an integer-arithmetic reference model.
module tb_alu16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  OpCode;
    logic [3:0]  FuncCode;
    logic [3:0]  RegOp2;
    logic        stall;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] ALUOut1;
    logic [15:0] ALUOut2;
    logic        Zero;
    logic        Sign;
    logic        Overflow;
    logic        DivByZero;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] o1;
        logic [15:0] o2;
        logic        z;
        logic        s;
        logic        v;
        logic        d;
    } res_t;

    res_t exp_r = '0;

    always #5 clk = ~clk;

    alu16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .OpCode    (OpCode),
        .FuncCode  (FuncCode),
        .RegOp2    (RegOp2),
        .stall     (stall),
        .A         (A),
        .B         (B),
        .ALUOut1   (ALUOut1),
        .ALUOut2   (ALUOut2),
        .Zero      (Zero),
        .Sign      (Sign),
        .Overflow  (Overflow),
        .DivByZero (DivByZero)
    );

    // Reference: plain signed integer arithmetic on widened values
    function automatic res_t model(input logic [3:0] op, input logic [3:0] fc,
                                   input logic [3:0] amt, input logic [15:0] a,
                                   input logic [15:0] b);
        res_t   r;
        longint sa, sb, ua, res, rem, pw, pwc;
        int     f;
        logic   is_mul;
        r      = '0;
        sa     = longint'($signed(a));
        sb     = longint'($signed(b));
        ua     = longint'(a);
        pw     = longint'(1) << amt;
        pwc    = longint'(1) << (16 - int'(amt));
        f      = (op == 4'h0) ? int'(fc) : 0;
        is_mul = 1'b0;
        res    = 0;
        case (f)
            0: begin res = sa + sb; r.v = (res > 32767) || (res < -32768); end
            1: begin res = sa - sb; r.v = (res > 32767) || (res < -32768); end
            2: begin
                res    = sa * sb;
                is_mul = 1'b1;
                r.o2   = res[31:16];
                r.z    = (res == 0);
                r.s    = (res < 0);
            end
            3: begin
                if (sb == 0) begin
                    r.d = 1'b1;
                end else begin
                    res  = sa / sb;
                    rem  = sa % sb;
                    r.v  = (res > 32767);
                    r.o2 = rem[15:0];
                end
            end
            4:  res = longint'(a & b);
            5:  res = longint'(a | b);
            8:  res = (ua * pw) % 65536;
            9:  res = ua / pw;
            10: res = ((ua * pw) + (ua / pwc)) % 65536;
            11: res = ((ua / pw) + (ua * pwc)) % 65536;
            default: res = 0;
        endcase
        r.o1 = res[15:0];
        if (!is_mul) begin
            r.z = (r.o1 == 16'h0000);
            r.s = r.o1[15];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] fc, input logic [3:0] amt,
                         input logic [15:0] a, input logic [15:0] b);
        OpCode   = op;
        FuncCode = fc;
        RegOp2   = amt;
        A        = a;
        B        = b;
    endtask

    // One clock: update expectation from the inputs present at the edge, then check all outputs
    task automatic step(input string tag);
        if (!rst_n)      exp_r = '0;
        else if (!stall) exp_r = model(OpCode, FuncCode, RegOp2, A, B);
        @(posedge clk);
        #1;
        chk({tag, ".out1"}, ALUOut1, exp_r.o1);
        chk({tag, ".out2"}, ALUOut2, exp_r.o2);
        chk({tag, ".zero"}, {15'b0, Zero}, {15'b0, exp_r.z});
        chk({tag, ".sign"}, {15'b0, Sign}, {15'b0, exp_r.s});
        chk({tag, ".ovf"},  {15'b0, Overflow}, {15'b0, exp_r.v});
        chk({tag, ".dbz"},  {15'b0, DivByZero}, {15'b0, exp_r.d});
    endtask

    initial begin
        logic [3:0]  fn_list  [10];
        logic [15:0] plan_out [10];
        logic [15:0] ra, rb;
        logic [15:0] held1;

        fn_list  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
        plan_out = '{16'h1800, 16'h0600, 16'h0000, 16'h0001, 16'h0900,
                     16'h0F00, 16'h7800, 16'h01E0, 16'h7800, 16'h01E0};

        // Reset held for two cycles
        rst_n = 1'b0;
        stall = 1'b0;
        drive(4'h0, 4'h0, 4'h0, 16'h1234, 16'h5678);
        step("reset0");
        step("reset1");

        // Test-plan operand sweep across every defined function
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(4'h0, fn_list[i], 4'd3, 16'h0F00, 16'h0900);
            step("plan");
            chk("plan_const", ALUOut1, plan_out[i]);
            if (fn_list[i] == 4'd2) begin
                chk("mul_hi_const", ALUOut2, 16'h0087);
                chk("mul_zero_const", {15'b0, Zero}, 16'h0000);
            end
            if (fn_list[i] == 4'd3) chk("div_rem_const", ALUOut2, 16'h0600);
        end

        // Overflow cases
        drive(4'h0, 4'd0, 4'd0, 16'h7FFF, 16'h0001);
        step("add_ovf");
        chk("add_ovf_const", {14'b0, Overflow, Sign}, 16'h0003);
        drive(4'h0, 4'd1, 4'd0, 16'h8000, 16'h0001);
        step("sub_ovf");
        chk("sub_ovf_const", ALUOut1, 16'h7FFF);
        drive(4'h0, 4'd3, 4'd0, 16'h8000, 16'hFFFF);
        step("div_ovf");
        chk("div_ovf_const", {15'b0, Overflow}, 16'h0001);

        // Division corners
        drive(4'h0, 4'd3, 4'd0, 16'h1234, 16'h0000);
        step("div_zero");
        chk("div_zero_const", {14'b0, DivByZero, Zero}, 16'h0003);
        drive(4'h0, 4'd3, 4'd0, 16'hFFF9, 16'h0002);
        step("div_neg");
        chk("div_neg_q_const", ALUOut1, 16'hFFFD);
        chk("div_neg_r_const", ALUOut2, 16'hFFFF);

        // Shift by zero passes A through
        drive(4'h0, 4'd11, 4'd0, 16'hA5C3, 16'h0000);
        step("ror0");

        // Stall holds outputs while inputs change
        drive(4'h0, 4'd0, 4'd0, 16'h0001, 16'h0002);
        step("pre_stall");
        held1 = 16'h0003;
        stall = 1'b1;
        drive(4'h0, 4'd1, 4'd0, 16'h4000, 16'h0100);
        step("stall_a");
        drive(4'h0, 4'd2, 4'd0, 16'h0123, 16'h0456);
        step("stall_b");
        chk("stall_const", ALUOut1, held1);
        stall = 1'b0;
        step("unstall");

        // Reset has priority over stall
        stall = 1'b1;
        rst_n = 1'b0;
        step("rst_stall");
        rst_n = 1'b1;
        stall = 1'b0;

        // Non-R-type and undefined function code
        drive(4'h8, 4'd2, 4'd0, 16'h0F00, 16'h0900);
        step("non_rtype");
        chk("non_rtype_const", ALUOut1, 16'h1800);
        drive(4'h0, 4'd6, 4'd5, 16'h0F00, 16'h0900);
        step("undef6");
        chk("undef6_const", {15'b0, Zero}, 16'h0001);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 16'h0000;
                1: begin ra = 16'h8000; rb = 16'hFFFF; end
                2: ra = 16'h7FFF;
                default: ;
            endcase
            drive(($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ra, rb);
            stall = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 49) != 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu16.md
Name: alu16

Overview:
- 16-bit signed ALU for the term-project datapath's execute stage.
- OpCode 0 selects the R-type operation from FuncCode. Every other OpCode performs the address/immediate add A+B.
- Produces a primary result, a secondary result (multiply high word or divide remainder) and four status flags.
- All outputs are registered, with a pipeline stall hold.

Parameters:
- WIDTH, 16, operand and result width (the spec is written for 16; shift amounts are 4 bits).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- OpCode  in  4  instruction opcode; 0 = R-type
- FuncCode  in  4  R-type function select
- RegOp2  in  4  shift/rotate amount (0-15)
- stall  in  1  1 = hold all output registers
- A  in  16  signed operand 1
- B  in  16  signed operand 2
- ALUOut1  out  16  primary result, signed
- ALUOut2  out  16  secondary result (product high word or remainder), else 0
- Zero  out  1  result is zero
- Sign  out  1  result is negative
- Overflow  out  1  signed overflow
- DivByZero  out  1  divide attempted with B == 0

Behaviour:
- Compute is combinational; all six outputs are registered. Latency is 1 cycle: inputs sampled at edge N appear after edge N.
- Reset: rst_n = 0 at a rising edge clears ALUOut1, ALUOut2, Zero, Sign, Overflow and DivByZero to 0. Reset has priority over stall.
- Stall: when stall = 1 (and not in reset), every output register holds its value.
- R-type FuncCode (OpCode = 0), with ALUOut2 = 0 unless stated:
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 MUL: signed 32-bit product P. ALUOut1 = P[15:0], ALUOut2 = P[31:16].
  - 3 DIV: signed division truncating toward zero. ALUOut1 = quotient, ALUOut2 = remainder; the remainder takes the dividend's sign.
  - 4 AND: A&B.
  - 5 OR: A|B.
  - 8 SLL: A << RegOp2, logical.
  - 9 SRL: A >> RegOp2, logical (zero fill).
  - 10 ROL: A rotated left by RegOp2.
  - 11 ROR: A rotated right by RegOp2.
  - 6, 7, 12-15: ALUOut1 = ALUOut2 = 0.
- OpCode != 0: ALUOut1 = A+B and ALUOut2 = 0. FuncCode is ignored; flags follow the ADD rules.
- Zero:
  - ALUOut1 == 0 for all operations except MUL.
  - MUL: full 32-bit P == 0.
  - Undefined FuncCodes give Zero = 1.
- Sign:
  - ALUOut1[15] for all operations except MUL.
  - MUL: P[31].
- Overflow:
  - ADD: operands share a sign and the result sign differs.
  - SUB: operand signs differ and the result sign differs from A.
  - DIV: A = 0x8000 with B = 0xFFFF gives quotient 0x8000, remainder 0 and Overflow = 1.
  - MUL, logic, shift and rotate ops: 0.
- DivByZero:
  - DIV with B == 0: DivByZero = 1, ALUOut1 = ALUOut2 = 0, Overflow = 0, Zero = 1.
  - All other operations: DivByZero = 0.
- A shift or rotate amount of 0 passes A through unchanged.

Decomposition:
- Shared package alu_pkg: OpCode constant OP_RTYPE = 4'h0, and FuncCode constants:
  - FN_ADD = 0, FN_SUB = 1, FN_MUL = 2, FN_DIV = 3, FN_AND = 4, FN_OR = 5
  - FN_SLL = 8, FN_SRL = 9, FN_ROL = 10, FN_ROR = 11
- One natural sub-module: alu16_shifter, a combinational barrel shifter/rotator covering SLL, SRL, ROL and ROR by 0-15.
- Arithmetic, flag logic and the output registers stay in alu16.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles -> all outputs 0. Then release with A = 0x0F00, B = 0x0900, OpCode = 0, RegOp2 = 3, and step FuncCode one per cycle:
  - ADD -> 0x1800.
  - SUB -> 0x0600.
  - MUL -> ALUOut1 = 0x0000, ALUOut2 = 0x0087, Zero = 0.
  - DIV -> 0x0001 / 0x0600.
- Same operands, logic and shift/rotate group:
  - AND -> 0x0900.
  - OR -> 0x0F00.
  - SLL -> 0x7800.
  - SRL -> 0x01E0.
  - ROL -> 0x7800.
  - ROR -> 0x01E0.
  - All with flags 0.
- Overflow cases:
  - ADD 0x7FFF + 0x0001 -> 0x8000, Overflow = 1, Sign = 1.
  - SUB 0x8000 - 0x0001 -> 0x7FFF, Overflow = 1.
  - DIV 0x8000 / 0xFFFF -> 0x8000, Overflow = 1.
- Division corners:
  - DIV B = 0 -> DivByZero = 1, outputs 0, Zero = 1.
  - DIV 0xFFF9 (-7) / 0x0002 -> quotient 0xFFFD, remainder 0xFFFF.
- Stall and reset ordering:
  - stall = 1 while inputs change -> outputs frozen.
  - stall released -> new result 1 cycle later.
  - rst_n = 0 with stall = 1 -> outputs cleared.
- Non-R-type and undefined codes:
  - OpCode = 4'h8, A = 0x0F00, B = 0x0900 -> ALUOut1 = 0x1800, ALUOut2 = 0.
  - FuncCode = 6 with OpCode 0 -> outputs 0, Zero = 1.
